kbd_fifo_mmio: RTL and testbench
================================

// Module: kbd_fifo_mmio
// PURPOSE
//  Memory-mapped ASCII buffer between the PS/2 keyboard decoder (upstream) and the CPU data-memory map
//  (downstream). Captures each key strobe as one byte and lets the CPU pop bytes and poll a status word.
//  Provides the keyboard queue that the mem block exposes at its keyboard address window.
// PARAMETERS
//  DEPTH  8  entries; power of two, 2..128
//  AW     3  log2(DEPTH); count width is AW+1
// PORTS
//  clk       in   1     system clock (CLOCK_50 domain)
//  reset     in   1     asynchronous, active-high
//  kb_we     in   1     keyboard write strobe, level, may stay high several clk cycles per key
//  kb_ascii  in   8     ASCII code valid while kb_we high
//  rd_req    in   1     CPU pop request, level (driven from dmem read strobe + address decode)
//  clr       in   1     synchronous flush request, single-cycle
//  rd_data   out  8     byte popped by the most recent rd_req rising edge
//  count     out  AW+1  occupancy, 0..DEPTH
//  empty     out  1     count==0
//  full      out  1     count==DEPTH
//  ovf       out  1     sticky: a push was dropped because FIFO was full
//  status    out  32    {21'b0, ovf, full, empty, 4'b0, count} for AW=3; bits 8/9/10 fixed for any AW
// BEHAVIOUR
//  - Reset (async): rptr=wptr=0, count=0, rd_data=8'h00, ovf=0, edge-detect regs=0; empty=1, full=0.
//  - push = rising edge of kb_we (kb_we & ~kb_we_q), one push per strobe however long kb_we stays high.
//  - pop  = rising edge of rd_req, same rule. Both edge regs are updated every clk.
//  - push with kb_ascii==8'h00 is ignored (decoder emits 0 for non-printing keys); no state change.
//  - push, not full: mem[wptr]<=kb_ascii, wptr++ (mod DEPTH), count++.
//  - push, full, no pop: byte dropped, ovf<=1, pointers and count unchanged.
//  - pop, not empty: rd_data<=mem[rptr] on the same edge that advances rptr (mod DEPTH); count--.
//    rd_data is valid 1 clk after the rd_req rising edge and holds until the next pop.
//  - pop, empty: rd_data<=8'h00, no pointer or count change, no error flag.
//  - push+pop same cycle:
//    * empty: the pop returns 8'h00, the push is stored, count becomes 1. No bypass.
//    * full: both happen, count stays DEPTH, ovf unchanged.
//    * otherwise: both happen, count unchanged.
//  - clr: rptr=wptr=0, count=0, ovf=0, rd_data=8'h00. Wins over any push or pop in the same cycle;
//    edge regs still update, so a strobe held high across clr is not re-counted.
//  - Flags and status derive combinationally from the registered count/ovf, so they show the
//    post-update value one clk after the event.
//  - Storage: plain register array, no RAM inference required, no read-during-write hazard.
// STRUCTURE
//  - kbd_defs.vh (shared with mem): KBD_ST_EMPTY=8, KBD_ST_FULL=9, KBD_ST_OVF=10, keyboard
//    data/status address offsets.
//  - One sub-module, rise_edge (1-bit registered rising-edge detector, async reset), instantiated
//    twice (kb_we, rd_req).
//  - Top level holds pointers, count, storage, ovf and the status packing.
// TESTING
//  1. reset mid-stream after 3 pushes -> count=0, empty=1, rd_data=00, ovf=0; next push 'A' then pop -> rd_data=41.
//  2. push 'H','I' with kb_we held 5 clk each, then 2 pops -> count 1,2, then rd_data 48 then 49, empty=1.
//  3. 9 pushes 0x31..0x39 (DEPTH=8) -> full=1, ovf=1, status=32'h0000_0608; 8 pops return 31..38, 39 never returned.
//  4. pop on empty -> rd_data=00, count=0; push 00 -> count stays 0.
//  5. push 'x' and pop on same clk when count=3 -> count stays 3; when empty -> pop gives 00, count=1.
//  6. 4 pushes, then clr in same clk as push+pop -> count=0, ovf=0; 20 push/pop pairs confirm pointer wrap keeps order.

Source files
------------

// File: rtl/kbd_fifo_mmio_pkg.sv
// Shared keyboard-queue definitions: status bit positions, MMIO offsets
// and the per-cycle FIFO operation bundle.
package kbd_fifo_mmio_pkg;

    localparam int KBD_ST_EMPTY = 8;
    localparam int KBD_ST_FULL  = 9;
    localparam int KBD_ST_OVF   = 10;

    localparam logic [3:0] KBD_DATA_OFS = 4'h0;
    localparam logic [3:0] KBD_STAT_OFS = 4'h4;

    typedef struct packed {
        logic push;
        logic pop;
        logic flush;
    } kbd_op_t;

endpackage

// File: rtl/kbd_fifo_mmio_rise_edge.sv
// One-bit rising-edge detector; the previous level is registered.
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= 1'b0;
        else
            q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/kbd_fifo_mmio.sv
// Keyboard ASCII queue exposed to the CPU as a data byte plus status word.
// One byte is pushed per kb_we strobe and popped per rd_req strobe.
module kbd_fifo_mmio
    import kbd_fifo_mmio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          kb_we,
    input  logic [7:0]    kb_ascii,
    input  logic          rd_req,
    input  logic          clr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic [31:0]   status
);

    logic          kb_rise;
    logic          rd_rise;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    kbd_op_t       op;
    logic          do_push;
    logic          do_pop;

    rise_edge u_kb_edge (
        .clk   (clk),
        .reset (reset),
        .d     (kb_we),
        .rise  (kb_rise)
    );

    rise_edge u_rd_edge (
        .clk   (clk),
        .reset (reset),
        .d     (rd_req),
        .rise  (rd_rise)
    );

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A full queue still accepts a push when a pop frees a slot that cycle
    always_comb begin
        op.push  = kb_rise && (kb_ascii != 8'h00);
        op.pop   = rd_rise;
        op.flush = clr;
        do_pop   = op.pop && !empty;
        do_push  = op.push && (!full || op.pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            rd_data <= 8'h00;
            ovf     <= 1'b0;
        end else if (op.flush) begin
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            rd_data <= 8'h00;
            ovf     <= 1'b0;
        end else begin
            if (op.pop)
                rd_data <= empty ? 8'h00 : mem[rptr];
            if (do_pop)
                rptr <= rptr + 1'b1;
            if (do_push)
                wptr <= wptr + 1'b1;
            if (op.push && full && !op.pop)
                ovf <= 1'b1;
            unique case (1'b1)
                (do_push && !do_pop): count <= count + 1'b1;
                (do_pop && !do_push): count <= count - 1'b1;
                default:              count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !op.flush)
            mem[wptr] <= kb_ascii;
    end

    always_comb begin
        status               = '0;
        status[AW:0]         = count;
        status[KBD_ST_EMPTY] = empty;
        status[KBD_ST_FULL]  = full;
        status[KBD_ST_OVF]   = ovf;
    end

endmodule

// File: tb/tb_kbd_fifo_mmio.sv
// Bench for kbd_fifo_mmio: table vectors, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_kbd_fifo_mmio;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          CLOCK_50;
    logic          reset;
    logic          kb_we;
    logic [7:0]    kb_ascii;
    logic          rd_req;
    logic          clr;
    logic [7:0]    rd_data;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic [31:0]   status;

    int checks   = 0;
    int failures = 0;

    kbd_fifo_mmio #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (CLOCK_50),
        .reset    (reset),
        .kb_we    (kb_we),
        .kb_ascii (kb_ascii),
        .rd_req   (rd_req),
        .clr      (clr),
        .rd_data  (rd_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .status   (status)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model: a byte queue plus the last popped byte and sticky flag
    byte unsigned mq[$];
    logic [7:0]   m_rd;
    logic         m_ovf;
    logic         m_pwe;
    logic         m_prd;

    typedef struct {
        logic       we;
        logic [7:0] ascii;
        logic       rd;
        logic       c;
        logic [7:0] exp_rd;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic model_reset();
        mq.delete();
        m_rd  = 8'h00;
        m_ovf = 1'b0;
        m_pwe = 1'b0;
        m_prd = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [7:0] a,
                              input logic rd, input logic c);
        logic push;
        logic pop;
        int   n;
        push  = we && !m_pwe;
        pop   = rd && !m_prd;
        m_pwe = we;
        m_prd = rd;
        n     = mq.size();
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_rd  = 8'h00;
        end else begin
            if (pop) begin
                if (n == 0) begin
                    m_rd = 8'h00;
                end else begin
                    m_rd = mq[0];
                    void'(mq.pop_front());
                end
            end
            if (push && a != 8'h00) begin
                if (n == DEPTH && !pop)
                    m_ovf = 1'b1;
                else
                    mq.push_back(a);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string nm);
        logic [31:0] es;
        int n;
        n  = mq.size();
        es = '0;
        es[3:0] = 4'(n);
        es[8]   = (n == 0);
        es[9]   = (n == DEPTH);
        es[10]  = m_ovf;
        chk({nm, ".rd_data"}, 32'(rd_data), 32'(m_rd));
        chk({nm, ".count"},   32'(count),   32'(n));
        chk({nm, ".empty"},   32'(empty),   32'(n == 0));
        chk({nm, ".full"},    32'(full),    32'(n == DEPTH));
        chk({nm, ".ovf"},     32'(ovf),     32'(m_ovf));
        chk({nm, ".status"},  status,       es);
    endtask

    task automatic apply(input string nm, input logic we, input logic [7:0] a,
                         input logic rd, input logic c);
        kb_we    = we;
        kb_ascii = a;
        rd_req   = rd;
        clr      = c;
        @(posedge CLOCK_50);
        model_step(we, a, rd, c);
        #1;
        check_model(nm);
    endtask

    task automatic push_key(input string nm, input logic [7:0] a);
        apply(nm, 1'b1, a, 1'b0, 1'b0);
        apply(nm, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop_key(input string nm);
        apply(nm, 1'b0, 8'h00, 1'b1, 1'b0);
        apply(nm, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        kb_we    = 1'b0;
        kb_ascii = 8'h00;
        rd_req   = 1'b0;
        clr      = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        check_model("reset");
        chk("reset.status_const", status, 32'h0000_0100);

        // Held strobes, empty pops, zero bytes and simultaneous push/pop
        vq.push_back('{1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 4'd1});
        for (int i = 0; i < 4; i++)
            vq.push_back('{1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 4'd1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1});
        for (int i = 0; i < 5; i++)
            vq.push_back('{1'b1, 8'h49, 1'b0, 1'b0, 8'h00, 4'd2});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd2});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h48, 4'd1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h48, 4'd1});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h49, 4'd0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h49, 4'd0});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0});
        vq.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0});
        vq.push_back('{1'b1, 8'h78, 1'b1, 1'b0, 8'h00, 4'd1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1});
        vq.push_back('{1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 4'd2});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd2});
        vq.push_back('{1'b1, 8'h62, 1'b0, 1'b0, 8'h00, 4'd3});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd3});
        vq.push_back('{1'b1, 8'h79, 1'b1, 1'b0, 8'h78, 4'd3});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h78, 4'd3});

        foreach (vq[i]) begin
            apply("tbl", vq[i].we, vq[i].ascii, vq[i].rd, vq[i].c);
            chk($sformatf("tbl[%0d].rd", i), 32'(rd_data), 32'(vq[i].exp_rd));
            chk($sformatf("tbl[%0d].cnt", i), 32'(count), 32'(vq[i].exp_cnt));
            chk($sformatf("tbl[%0d].ovf", i), 32'(ovf), 32'd0);
        end

        // Asynchronous reset in the middle of traffic
        apply("pre_rst", 1'b0, 8'h00, 1'b0, 1'b1);
        push_key("pre_rst", 8'h31);
        push_key("pre_rst", 8'h32);
        push_key("pre_rst", 8'h33);
        #3;
        reset = 1'b1;
        #2;
        model_reset();
        chk("async_rst.count", 32'(count), 32'd0);
        chk("async_rst.empty", 32'(empty), 32'd1);
        chk("async_rst.rd", 32'(rd_data), 32'h00);
        chk("async_rst.ovf", 32'(ovf), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        push_key("post_rst", 8'h41);
        pop_key("post_rst");
        chk("post_rst.rd_A", 32'(rd_data), 32'h41);

        // Overflow: nine pushes into eight slots
        for (int i = 0; i < 9; i++)
            push_key("fill", 8'(8'h31 + i));
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.ovf", 32'(ovf), 32'd1);
        chk("fill.status", status, 32'h0000_0608);
        for (int i = 0; i < 8; i++) begin
            pop_key("drain");
            chk($sformatf("drain[%0d]", i), 32'(rd_data), 32'(8'h31 + i));
        end
        chk("drain.empty", 32'(empty), 32'd1);
        pop_key("drain_extra");
        chk("drain_extra.rd", 32'(rd_data), 32'h00);
        chk("drain.ovf_sticky", 32'(ovf), 32'd1);

        // Clear beats a simultaneous push and pop; held strobe not recounted
        for (int i = 0; i < 4; i++)
            push_key("pre_clr", 8'(8'h61 + i));
        apply("clr", 1'b1, 8'h7a, 1'b1, 1'b1);
        chk("clr.count", 32'(count), 32'd0);
        chk("clr.ovf", 32'(ovf), 32'd0);
        chk("clr.rd", 32'(rd_data), 32'h00);
        apply("clr_hold", 1'b1, 8'h7a, 1'b1, 1'b0);
        chk("clr_hold.count", 32'(count), 32'd0);
        apply("clr_rel", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push_key("wrap", 8'(8'h41 + i));
            pop_key("wrap");
            chk($sformatf("wrap[%0d]", i), 32'(rd_data), 32'(8'h41 + i));
        end

        // Full queue with push and pop on the same edge
        for (int i = 0; i < 8; i++)
            push_key("full_pp", 8'(8'h50 + i));
        apply("full_pp", 1'b1, 8'h58, 1'b1, 1'b0);
        chk("full_pp.count", 32'(count), 32'd8);
        chk("full_pp.rd", 32'(rd_data), 32'h50);
        chk("full_pp.ovf", 32'(ovf), 32'd0);
        apply("full_pp", 1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       we;
            logic       rd;
            logic       c;
            logic [7:0] a;
            we = ($urandom_range(0, 99) < 45);
            rd = ($urandom_range(0, 99) < 35);
            c  = ($urandom_range(0, 99) < 2);
            a  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            apply("rand", we, a, rd, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
